// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, controller states and byte-enable helper for data_memory_unit
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  typedef enum logic [1:0] {INIT, IDLE, RD_WAIT, RESP} state_t;
  function automatic logic [3:0] be_from_size(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_BYTE ? 4'b0001 << off :
           size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) :
           size == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/dmem_align.sv
// dmem_align: store lane replication and load byte/half extract with sign/zero extension
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [31:0] o_wlanes,
  output logic [31:0] o_rdata
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign o_wlanes = i_size == SZ_BYTE ? {4{i_wdata[7:0]}} :
                    i_size == SZ_HALF ? {2{i_wdata[15:0]}} : i_wdata;
  assign w_byte   = i_rword[8*i_off +: 8];
  assign w_half   = i_off[1] ? i_rword[31:16] : i_rword[15:0];
  assign o_rdata  = i_size == SZ_BYTE ? {{24{~i_unsigned & w_byte[7]}}, w_byte} :
                    i_size == SZ_HALF ? {{16{~i_unsigned & w_half[15]}}, w_half} : i_rword;
endmodule

// File: rtl/data_memory_unit.sv
// data_memory_unit: load/store data memory with clear-on-reset sweep; DMEM_DEBUG_TAP_EN exposes words 0..2
module data_memory_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_init_done,
  output logic [31:0]       o_dbg_d0,
  output logic [31:0]       o_dbg_d1,
  output logic [31:0]       o_dbg_d2
);
  localparam int IDX_W = $clog2(DEPTH);
  state_t           r_state;
  logic [IDX_W-1:0] r_clr_ptr;
  logic [1:0]       r_cnt;
  logic             r_init_done;
  logic             r_err;
  logic [31:0]      r_rdata;
  logic [31:0]      r_mem [DEPTH];
  logic             w_accept;
  logic             w_err;
  logic             w_load;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_off;
  logic [3:0]       w_be;
  logic [31:0]      w_wlanes;
  logic [31:0]      w_ldata;
  assign o_req_ready  = r_state == IDLE || r_state == RESP;
  assign w_accept     = i_req_valid && o_req_ready;
  assign w_idx        = i_req_addr[IDX_W+1:2];
  assign w_off        = i_req_addr[1:0];
  assign w_err        = i_req_addr >= ADDR_W'(DEPTH*4) || i_req_size == 2'd3 ||
                        (i_req_size == SZ_HALF && w_off[0]) ||
                        (i_req_size == SZ_WORD && w_off != 2'b00);
  assign w_be         = w_accept && i_req_write && !w_err ? be_from_size(i_req_size, w_off) : 4'b0000;
  assign w_load       = w_accept && !i_req_write && !w_err;
  assign o_resp_valid = r_state == RESP;
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;
  assign o_init_done  = r_init_done;
  dmem_align u_align (
    .i_size     (i_req_size),
    .i_off      (w_off),
    .i_unsigned (i_req_unsigned),
    .i_wdata    (i_req_wdata),
    .i_rword    (r_mem[w_idx]),
    .o_wlanes   (w_wlanes),
    .o_rdata    (w_ldata)
  );
  // Storage: clear sweep during INIT, byte-lane stores at the accept edge
  always_ff @(posedge i_clock) begin
    if (r_state == INIT) r_mem[r_clr_ptr] <= '0;
    for (int b = 0; b < 4; b++) if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
  end
  // Controller: init sweep, request accept, read-latency wait and response registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= INIT;
      r_clr_ptr   <= '0;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == IDX_W'(DEPTH-1)) begin
            r_state     <= IDLE;
            r_init_done <= 1'b1;
          end
        end
        RD_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == 2'd0) r_state <= RESP;
        end
        default: r_state <= !w_accept ? IDLE : (w_load && READ_LAT > 1) ? RD_WAIT : RESP;
      endcase
      if (w_accept) begin
        r_err   <= w_err;
        r_rdata <= w_load ? w_ldata : '0;
        r_cnt   <= 2'(READ_LAT-2);
      end else if (r_state == RESP) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end
`ifdef DMEM_DEBUG_TAP_EN
  assign o_dbg_d0 = r_mem[0];
  assign o_dbg_d1 = r_mem[1];
  assign o_dbg_d2 = r_mem[2];
`else
  assign o_dbg_d0 = '0;
  assign o_dbg_d1 = '0;
  assign o_dbg_d2 = '0;
`endif
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: directed vector bench for data_memory_unit at READ_LAT 1 and 3
module tb_data_memory_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        v1, v3, wr, uns;
  logic [1:0]  sz;
  logic [31:0] addr, wdata;
  logic        rdy1, rv1, er1, id1, rdy3, rv3, er3, id3;
  logic [31:0] rd1, rd3, d0a, d1a, d2a, d0b, d1b, d2b;
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  data_memory_unit #(.DEPTH(64), .READ_LAT(1), .ADDR_W(32)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_req_valid(v1), .o_req_ready(rdy1),
    .i_req_write(wr), .i_req_size(sz), .i_req_unsigned(uns), .i_req_addr(addr),
    .i_req_wdata(wdata), .o_resp_valid(rv1), .o_resp_rdata(rd1), .o_resp_err(er1),
    .o_init_done(id1), .o_dbg_d0(d0a), .o_dbg_d1(d1a), .o_dbg_d2(d2a)
  );
  data_memory_unit #(.DEPTH(64), .READ_LAT(3), .ADDR_W(32)) dut3 (
    .i_clock(clk), .i_reset_n(rst_n), .i_req_valid(v3), .o_req_ready(rdy3),
    .i_req_write(wr), .i_req_size(sz), .i_req_unsigned(uns), .i_req_addr(addr),
    .i_req_wdata(wdata), .o_resp_valid(rv3), .o_resp_rdata(rd3), .o_resp_err(er3),
    .o_init_done(id3), .o_dbg_d0(d0b), .o_dbg_d1(d1b), .o_dbg_d2(d2b)
  );
  typedef struct {
    string       name;
    bit          wr;
    logic [1:0]  sz;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input bit s3, input bit w, input logic [1:0] s, input bit u,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output bit er, output int lat);
    int n;
    n = 0;
    while (!(s3 ? rdy3 : rdy1) && n < 100) begin
      tick();
      n++;
    end
    chk("txn.ready", 32'(s3 ? rdy3 : rdy1), 32'd1);
    wr = w; sz = s; uns = u; addr = a; wdata = d;
    if (s3) v3 = 1'b1; else v1 = 1'b1;
    tick();
    v1 = 1'b0; v3 = 1'b0;
    lat = 1;
    while (!(s3 ? rv3 : rv1) && lat < 20) begin
      tick();
      lat++;
    end
    rd = s3 ? rd3 : rd1;
    er = s3 ? er3 : er1;
  endtask
  task automatic wait_init(input string n);
    int c;
    c = 0;
    while (!rdy1 && c < 200) begin
      tick();
      c++;
    end
    chk({n, ".cycles"}, 32'(c), 32'd64);
    chk({n, ".done1"}, 32'(id1), 32'd1);
    chk({n, ".done3"}, 32'(id3), 32'd1);
    chk({n, ".ready3"}, 32'(rdy3), 32'd1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] rd;
    bit er;
    int lat;
    vecs.push_back('{"lw_init_0", 0, 2'd2, 0, 32'h00, 32'h0,        32'h00000000, 0});
    vecs.push_back('{"sw_8",      1, 2'd2, 0, 32'h08, 32'hDEADBEEF, 32'h00000000, 0});
    vecs.push_back('{"lw_8",      0, 2'd2, 0, 32'h08, 32'h0,        32'hDEADBEEF, 0});
    vecs.push_back('{"sb_5",      1, 2'd0, 0, 32'h05, 32'h00000080, 32'h00000000, 0});
    vecs.push_back('{"lb_5",      0, 2'd0, 0, 32'h05, 32'h0,        32'hFFFFFF80, 0});
    vecs.push_back('{"lbu_5",     0, 2'd0, 1, 32'h05, 32'h0,        32'h00000080, 0});
    vecs.push_back('{"lw_4",      0, 2'd2, 0, 32'h04, 32'h0,        32'h00008000, 0});
    vecs.push_back('{"lh_3_mis",  0, 2'd1, 0, 32'h03, 32'h0,        32'h00000000, 1});
    vecs.push_back('{"sw_oor",    1, 2'd2, 0, 32'h100, 32'h12345678, 32'h00000000, 1});
    vecs.push_back('{"lw_0_unch", 0, 2'd2, 0, 32'h00, 32'h0,        32'h00000000, 0});
    vecs.push_back('{"lw_8_unch", 0, 2'd2, 0, 32'h08, 32'h0,        32'hDEADBEEF, 0});
    vecs.push_back('{"sh_a",      1, 2'd1, 0, 32'h0A, 32'hFFFFABCD, 32'h00000000, 0});
    vecs.push_back('{"lh_a",      0, 2'd1, 0, 32'h0A, 32'h0,        32'hFFFFABCD, 0});
    vecs.push_back('{"lhu_a",     0, 2'd1, 1, 32'h0A, 32'h0,        32'h0000ABCD, 0});
    vecs.push_back('{"lw_8_merge",0, 2'd2, 0, 32'h08, 32'h0,        32'hABCDBEEF, 0});
    vecs.push_back('{"lb_b",      0, 2'd0, 0, 32'h0B, 32'h0,        32'hFFFFFFAB, 0});
    vecs.push_back('{"lbu_9",     0, 2'd0, 1, 32'h09, 32'h0,        32'h000000BE, 0});
    vecs.push_back('{"lb_8",      0, 2'd0, 0, 32'h08, 32'h0,        32'hFFFFFFEF, 0});
    vecs.push_back('{"sz3",       0, 2'd3, 0, 32'h00, 32'h0,        32'h00000000, 1});
    vecs.push_back('{"sw_mis",    1, 2'd2, 0, 32'h02, 32'h11111111, 32'h00000000, 1});
    vecs.push_back('{"lw_mis",    0, 2'd2, 0, 32'h01, 32'h0,        32'h00000000, 1});
    vecs.push_back('{"lw_0_after",0, 2'd2, 0, 32'h00, 32'h0,        32'h00000000, 0});
    vecs.push_back('{"sw_last",   1, 2'd2, 0, 32'hFC, 32'h11223344, 32'h00000000, 0});
    vecs.push_back('{"lh_last",   0, 2'd1, 0, 32'hFE, 32'h0,        32'h00001122, 0});
    vecs.push_back('{"lw_last",   0, 2'd2, 0, 32'hFC, 32'h0,        32'h11223344, 0});
    vecs.push_back('{"lbu_oor",   0, 2'd0, 1, 32'h104, 32'h0,       32'h00000000, 1});
    rst_n = 1'b0; v1 = 1'b0; v3 = 1'b0; wr = 1'b0; uns = 1'b0; sz = 2'd0; addr = '0; wdata = '0;
    repeat (3) tick();
    chk("rst.ready", 32'(rdy1), 32'd0);
    chk("rst.resp_valid", 32'(rv1), 32'd0);
    chk("rst.resp_err", 32'(er1), 32'd0);
    chk("rst.resp_rdata", rd1, 32'd0);
    chk("rst.init_done", 32'(id1), 32'd0);
    rst_n = 1'b1;
    wait_init("init");
    foreach (vecs[i]) begin
      txn(0, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk({vecs[i].name, ".rdata"}, rd, vecs[i].rdata);
      chk({vecs[i].name, ".err"}, 32'(er), 32'(vecs[i].err));
      chk({vecs[i].name, ".lat"}, 32'(lat), 32'd1);
    end
    tick();
    chk("pulse.one_cycle", 32'(rv1), 32'd0);
`ifdef DMEM_DEBUG_TAP_EN
    chk("dbg.d0", d0a, 32'h00000000);
    chk("dbg.d1", d1a, 32'h00008000);
    chk("dbg.d2", d2a, 32'hABCDBEEF);
`else
    chk("dbg.d1_tied", d1a, 32'd0);
    chk("dbg.d2_tied", d2a, 32'd0);
`endif
    wr = 1'b1; sz = 2'd2; uns = 1'b0; addr = 32'h10; wdata = 32'hCAFEF00D; v1 = 1'b1;
    tick();
    chk("b2b.store_resp", 32'(rv1), 32'd1);
    chk("b2b.store_rdata", rd1, 32'd0);
    chk("b2b.ready_in_resp", 32'(rdy1), 32'd1);
    wr = 1'b0;
    tick();
    v1 = 1'b0;
    chk("b2b.load_resp", 32'(rv1), 32'd1);
    chk("b2b.load_rdata", rd1, 32'hCAFEF00D);
    chk("b2b.load_err", 32'(er1), 32'd0);
    tick();
    chk("b2b.pulse_end", 32'(rv1), 32'd0);
    wr = 1'b0; sz = 2'd2; addr = 32'h0; v3 = 1'b1;
    tick();
    v3 = 1'b0;
    chk("lat3.t1", {30'd0, rdy3, rv3}, 32'd0);
    tick();
    chk("lat3.t2", {30'd0, rdy3, rv3}, 32'd0);
    tick();
    chk("lat3.t3", {30'd0, rdy3, rv3}, 32'd3);
    chk("lat3.t3_rdata", rd3, 32'd0);
    txn(1, 1, 2'd2, 0, 32'h0C, 32'h55AA00FF, rd, er, lat);
    chk("lat3.sw.lat", 32'(lat), 32'd1);
    chk("lat3.sw.err", 32'(er), 32'd0);
    txn(1, 0, 2'd0, 0, 32'h0C, 32'h0, rd, er, lat);
    chk("lat3.lb.lat", 32'(lat), 32'd3);
    chk("lat3.lb.rdata", rd, 32'hFFFFFFFF);
    txn(1, 0, 2'd1, 1, 32'h0E, 32'h0, rd, er, lat);
    chk("lat3.lhu.rdata", rd, 32'h000055AA);
    txn(1, 0, 2'd1, 0, 32'h0D, 32'h0, rd, er, lat);
    chk("lat3.mis.lat", 32'(lat), 32'd1);
    chk("lat3.mis.err", 32'(er), 32'd1);
    wr = 1'b0; sz = 2'd2; addr = 32'h0C; v3 = 1'b1;
    tick();
    v3 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.resp_valid", 32'(rv3), 32'd0);
    chk("arst.ready", 32'(rdy3), 32'd0);
    chk("arst.init_done", 32'(id1 | id3), 32'd0);
    tick();
    chk("arst.hold1", 32'(rv3), 32'd0);
    tick();
    chk("arst.hold2", 32'(rv3), 32'd0);
    rst_n = 1'b1;
    wait_init("reinit");
    txn(0, 0, 2'd2, 0, 32'h08, 32'h0, rd, er, lat);
    chk("reinit.lw8", rd, 32'd0);
    txn(1, 0, 2'd2, 0, 32'h0C, 32'h0, rd, er, lat);
    chk("reinit.lw_c", rd, 32'd0);
    chk("reinit.lw_c.lat", 32'(lat), 32'd3);
    chk("reinit.dbg_d2", d2a, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
